systolic_controller: RTL and testbench

SYSTOLIC_CONTROLLER -- requirements
Module: systolic_controller

---
 rtl/systolic_controller_if.sv | 20 ++
 rtl/systolic_controller.sv | 199 +++++++++++++++++++
 tb/tb_systolic_controller.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_controller_if.sv
// State type shared with the bench, plus the single-port memory bus used by the systolic controller.
package SystolicTypes;
  typedef enum logic [2:0] {
    IDLE             = 3'd0,
    WAITING_MEMORY_A = 3'd1,
    WAITING_MEMORY_B = 3'd2,
    COMPUTE          = 3'd3,
    WRITEBACK        = 3'd4
  } state_t;
endpackage

interface systolic_controller_if #(parameter int WIDTH = 16);
  logic [11:0]      mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_write;
  logic [WIDTH-1:0] mem_rdata;

  modport master (output mem_addr, output mem_wdata, output mem_write, input mem_rdata);
  modport slave  (input mem_addr, input mem_wdata, input mem_write, output mem_rdata);
endinterface

// File: rtl/systolic_controller.sv
// Sequential matrix-multiply controller: fetches A/B elements one at a time over a
// single-port memory, accumulates dot products and writes saturated C elements back.
//
// state            | meaning
// IDLE             | waiting for a valid start request
// WAITING_MEMORY_A | address A[i][k] on the bus
// WAITING_MEMORY_B | address B[k][j] on the bus, capture A element
// COMPUTE          | multiply-accumulate with the B element
// WRITEBACK        | write saturated C[i][j], advance j/i
module systolic_controller
  import SystolicTypes::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         new_data,
  input  logic [11:0]                  addr_A,
  input  logic [11:0]                  addr_B,
  input  logic [11:0]                  addr_C,
  input  logic [8:0]                   matrix_N,
  input  logic                         stepping_enable,
  input  logic                         step,
  systolic_controller_if.master        mem,
  output state_t                       fsm_state,
  output logic [15:0]                  cycle_count,
  output logic [31:0]                  int_ops,
  output logic                         op_done,
  output logic                         overflow
);

  localparam logic [39:0] MAX_VAL = (40'd1 << WIDTH) - 40'd1;

  state_t           state_q, state_d;
  logic [11:0]      addr_a_q, addr_a_d, addr_b_q, addr_b_d, addr_c_q, addr_c_d;
  logic [8:0]       n_q, n_d;
  logic [7:0]       i_q, i_d, j_q, j_d, k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [39:0]      acc_q, acc_d;
  logic [15:0]      cyc_q, cyc_d;
  logic [31:0]      ops_q, ops_d;
  logic             done_q, done_d, ovf_q, ovf_d;
  logic             fresh_q, fresh_d;

  logic             advance, start_ok, k_last, j_last, i_last, sat;
  logic [11:0]      i_n, k_n;
  logic [WIDTH-1:0] opnd_b;
  logic [2*WIDTH-1:0] prod;

  assign advance  = !stepping_enable || step;
  assign start_ok = new_data && (matrix_N != 9'd0) && (matrix_N <= 9'd128);
  assign k_last   = ({1'b0, k_q} == n_q - 9'd1);
  assign j_last   = ({1'b0, j_q} == n_q - 9'd1);
  assign i_last   = ({1'b0, i_q} == n_q - 9'd1);
  assign i_n      = 12'(i_q) * 12'(n_q);
  assign k_n      = 12'(k_q) * 12'(n_q);
  assign sat      = acc_q > MAX_VAL;

  // Read data only tracks the address held one cycle earlier, so under a step
  // stall the operand seen on the first cycle of a state is kept in b_q.
  assign opnd_b   = fresh_q ? mem.mem_rdata : b_q;
  assign prod     = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, opnd_b};

  always_comb begin
    state_d       = state_q;
    addr_a_d      = addr_a_q;
    addr_b_d      = addr_b_q;
    addr_c_d      = addr_c_q;
    n_d           = n_q;
    i_d           = i_q;
    j_d           = j_q;
    k_d           = k_q;
    a_d           = a_q;
    b_d           = b_q;
    acc_d         = acc_q;
    ops_d         = ops_q;
    done_d        = done_q;
    ovf_d         = ovf_q;
    cyc_d         = cyc_q;
    mem.mem_addr  = 12'd0;
    mem.mem_wdata = '0;
    mem.mem_write = 1'b0;

    if (state_q != IDLE && cyc_q != 16'hFFFF) cyc_d = cyc_q + 16'd1;

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          addr_a_d = addr_A;
          addr_b_d = addr_B;
          addr_c_d = addr_C;
          n_d      = matrix_N;
          i_d      = 8'd0;
          j_d      = 8'd0;
          k_d      = 8'd0;
          acc_d    = 40'd0;
          cyc_d    = 16'd0;
          ops_d    = 32'd0;
          done_d   = 1'b0;
          ovf_d    = 1'b0;
          state_d  = WAITING_MEMORY_A;
        end
      end
      WAITING_MEMORY_A: begin
        mem.mem_addr = addr_a_q + i_n + 12'(k_q);
        if (advance) state_d = WAITING_MEMORY_B;
      end
      WAITING_MEMORY_B: begin
        mem.mem_addr = addr_b_q + k_n + 12'(j_q);
        if (fresh_q) a_d = mem.mem_rdata;
        if (advance) state_d = COMPUTE;
      end
      COMPUTE: begin
        if (fresh_q) b_d = mem.mem_rdata;
        if (advance) begin
          acc_d = acc_q + 40'(prod);
          ops_d = ops_q + 32'd2;
          if (k_last) begin
            state_d = WRITEBACK;
          end else begin
            k_d     = k_q + 8'd1;
            state_d = WAITING_MEMORY_A;
          end
        end
      end
      WRITEBACK: begin
        mem.mem_write = 1'b1;
        mem.mem_addr  = addr_c_q + i_n + 12'(j_q);
        mem.mem_wdata = sat ? MAX_VAL[WIDTH-1:0] : acc_q[WIDTH-1:0];
        if (advance) begin
          if (sat) ovf_d = 1'b1;
          acc_d = 40'd0;
          k_d   = 8'd0;
          if (j_last) begin
            j_d = 8'd0;
            if (i_last) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              i_d     = i_q + 8'd1;
              state_d = WAITING_MEMORY_A;
            end
          end else begin
            j_d     = j_q + 8'd1;
            state_d = WAITING_MEMORY_A;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    fresh_d = (state_d != state_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_a_q <= 12'd0;
      addr_b_q <= 12'd0;
      addr_c_q <= 12'd0;
      n_q      <= 9'd0;
      i_q      <= 8'd0;
      j_q      <= 8'd0;
      k_q      <= 8'd0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= 40'd0;
      cyc_q    <= 16'd0;
      ops_q    <= 32'd0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      fresh_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      addr_c_q <= addr_c_d;
      n_q      <= n_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cyc_q    <= cyc_d;
      ops_q    <= ops_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      fresh_q  <= fresh_d;
    end
  end

  assign fsm_state   = state_q;
  assign cycle_count = cyc_q;
  assign int_ops     = ops_q;
  assign op_done     = done_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_systolic_controller.sv
// Directed bench for systolic_controller: behavioural memory, write logger and a
// scoreboard of expected C writes computed from a shadow copy of the loaded data.
module tb_systolic_controller;
  import SystolicTypes::*;

  localparam int WIDTH = 16;

  typedef struct packed {
    logic [11:0]      addr;
    logic [WIDTH-1:0] data;
  } wr_t;

  logic             clk = 1'b0;
  logic             rst, new_data, stepping_enable, step;
  logic [11:0]      addr_A, addr_B, addr_C;
  logic [8:0]       matrix_N;
  state_t           fsm_state;
  logic [15:0]      cycle_count;
  logic [31:0]      int_ops;
  logic             op_done, overflow;

  logic             ld_we;
  logic [11:0]      ld_addr;
  logic [WIDTH-1:0] ld_data;
  logic [WIDTH-1:0] mem    [0:4095];
  logic [WIDTH-1:0] shadow [0:4095];

  wr_t exp_q[$];
  wr_t obs [0:63];
  int  obs_cnt = 0;
  int  obs_rd  = 0;
  int  checks  = 0;
  int  errors  = 0;

  systolic_controller_if #(.WIDTH(WIDTH)) bus ();

  systolic_controller #(.WIDTH(WIDTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .new_data        (new_data),
    .addr_A          (addr_A),
    .addr_B          (addr_B),
    .addr_C          (addr_C),
    .matrix_N        (matrix_N),
    .stepping_enable (stepping_enable),
    .step            (step),
    .mem             (bus.master),
    .fsm_state       (fsm_state),
    .cycle_count     (cycle_count),
    .int_ops         (int_ops),
    .op_done         (op_done),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld_we) mem[ld_addr] <= ld_data;
    else if (bus.mem_write && (!stepping_enable || step)) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  // Log each committed write, sampled mid-way through the low clock phase.
  always @(negedge clk) begin
    #2;
    if (bus.mem_write && (!stepping_enable || step) && obs_cnt < 64) begin
      obs[obs_cnt] <= '{addr: bus.mem_addr, data: bus.mem_wdata};
      obs_cnt      <= obs_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic poke(input int a, input logic [WIDTH-1:0] d);
    @(negedge clk);
    ld_addr   = 12'(a);
    ld_data   = d;
    ld_we     = 1'b1;
    shadow[a] = d;
    @(negedge clk);
    ld_we     = 1'b0;
  endtask

  task automatic start(input int a, input int b, input int c, input int n);
    @(negedge clk);
    addr_A   = 12'(a);
    addr_B   = 12'(b);
    addr_C   = 12'(c);
    matrix_N = 9'(n);
    new_data = 1'b1;
    @(negedge clk);
    new_data = 1'b0;
  endtask

  task automatic push_model(input int n, input int ab, input int bb, input int cb);
    longint max_v = longint'((64'd1 << WIDTH) - 64'd1);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        longint s = 0;
        wr_t    e;
        for (int k = 0; k < n; k++)
          s += longint'(shadow[(ab + i * n + k) % 4096]) * longint'(shadow[(bb + k * n + j) % 4096]);
        e.addr = 12'((cb + i * n + j) % 4096);
        e.data = (s > max_v) ? {WIDTH{1'b1}} : WIDTH'(s);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic wait_done(input string tag);
    for (int t = 0; t < 2000 && !op_done; t++) @(negedge clk);
    chk({tag, " op_done"}, 64'(op_done), 64'd1);
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      wr_t e = exp_q.pop_front();
      if (obs_rd < obs_cnt) begin
        chk({tag, " wr addr"}, 64'(obs[obs_rd].addr), 64'(e.addr));
        chk({tag, " wr data"}, 64'(obs[obs_rd].data), 64'(e.data));
      end else begin
        chk({tag, " missing write"}, 64'(obs_cnt), 64'(obs_rd + 1));
      end
      obs_rd++;
    end
    chk({tag, " write count"}, 64'(obs_cnt), 64'(obs_rd));
    obs_rd = obs_cnt;
  endtask

  initial begin
    int saved_cc, saved_obs;
    rst = 1'b1; new_data = 1'b0; stepping_enable = 1'b0; step = 1'b0;
    addr_A = '0; addr_B = '0; addr_C = '0; matrix_N = '0;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0;

    #12;
    chk("reset state", 64'(fsm_state), 64'(IDLE));
    chk("reset mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("reset mem_write", 64'(bus.mem_write), 64'd0);
    chk("reset cycle_count", 64'(cycle_count), 64'd0);
    chk("reset op_done", 64'(op_done), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // N=1 single product
    poke(0, 16'd3);
    poke(1, 16'd5);
    push_model(1, 0, 1, 2);
    start(0, 1, 2, 1);
    chk("n1 state after start", 64'(fsm_state), 64'(WAITING_MEMORY_A));
    wait_done("n1");
    drain("n1");
    chk("n1 cycle_count", 64'(cycle_count), 64'd4);
    chk("n1 int_ops", 64'(int_ops), 64'd2);
    chk("n1 overflow", 64'(overflow), 64'd0);
    chk("n1 mem[2]", 64'(mem[2]), 64'd15);
    chk("n1 idle mem_addr", 64'(bus.mem_addr), 64'd0);

    // N=2 identity x [[1,2],[3,4]]
    poke(4, 16'd1); poke(5, 16'd0); poke(6, 16'd0); poke(7, 16'd1);
    poke(12, 16'd1); poke(13, 16'd2); poke(14, 16'd3); poke(15, 16'd4);
    push_model(2, 4, 12, 8);
    start(4, 12, 8, 2);
    wait_done("n2");
    drain("n2");
    chk("n2 cycle_count", 64'(cycle_count), 64'd28);
    chk("n2 int_ops", 64'(int_ops), 64'd16);
    chk("n2 mem[11]", 64'(mem[11]), 64'd4);

    // N=1 saturation then overflow cleared by next start
    poke(20, 16'hFFFF);
    poke(21, 16'hFFFF);
    push_model(1, 20, 21, 22);
    start(20, 21, 22, 1);
    wait_done("sat");
    drain("sat");
    chk("sat overflow", 64'(overflow), 64'd1);
    push_model(1, 0, 1, 2);
    start(0, 1, 2, 1);
    chk("restart overflow", 64'(overflow), 64'd0);
    chk("restart op_done", 64'(op_done), 64'd0);
    wait_done("restart");
    drain("restart");
    chk("restart overflow end", 64'(overflow), 64'd0);

    // Invalid N requests are ignored
    saved_cc  = int'(cycle_count);
    saved_obs = obs_cnt;
    start(0, 1, 2, 0);
    chk("n0 state", 64'(fsm_state), 64'(IDLE));
    start(0, 1, 2, 129);
    chk("n129 state", 64'(fsm_state), 64'(IDLE));
    repeat (4) @(negedge clk);
    chk("invalid op_done", 64'(op_done), 64'd1);
    chk("invalid cycle_count", 64'(cycle_count), 64'(saved_cc));
    chk("invalid writes", 64'(obs_cnt), 64'(saved_obs));

    // Reset while in COMPUTE of an N=2 run
    poke(40, 16'h5A5A);
    saved_obs = obs_cnt;
    start(4, 12, 40, 2);
    for (int t = 0; t < 50 && fsm_state != COMPUTE; t++) @(negedge clk);
    chk("reach compute", 64'(fsm_state), 64'(COMPUTE));
    #2 rst = 1'b1;
    #1;
    chk("abort state", 64'(fsm_state), 64'(IDLE));
    chk("abort mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("abort mem_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("abort cycle_count", 64'(cycle_count), 64'd0);
    chk("abort int_ops", 64'(int_ops), 64'd0);
    chk("abort op_done", 64'(op_done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort no writes", 64'(obs_cnt), 64'(saved_obs));
    chk("abort mem[40]", 64'(mem[40]), 64'h5A5A);
    chk("abort op_done later", 64'(op_done), 64'd0);

    // Single-step mode
    stepping_enable = 1'b1;
    step            = 1'b0;
    push_model(1, 0, 1, 50);
    start(0, 1, 50, 1);
    repeat (10) @(negedge clk);
    chk("step frozen state", 64'(fsm_state), 64'(WAITING_MEMORY_A));
    chk("step cycle_count", 64'(cycle_count), 64'd10);
    chk("step mem_addr held", 64'(bus.mem_addr), 64'd0);
    for (int p = 0; p < 4; p++) begin
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      @(negedge clk);
    end
    chk("step final state", 64'(fsm_state), 64'(IDLE));
    chk("step op_done", 64'(op_done), 64'd1);
    drain("step");
    chk("step mem[50]", 64'(mem[50]), 64'd15);
    stepping_enable = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
